// File: rtl/operand_reader_pkg.sv
// Shared types and helpers for the instruction-decode operand reader.
// Holds the FSM state encoding and the sign-fill rule for the upper byte lanes.
package operand_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Fill byte for lanes above the last byte read.
    function automatic logic [7:0] sign_fill(input logic [7:0] last_byte, input logic enable);
        return (enable && last_byte[7]) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/operand_reader_arbiter.sv
// Purely combinational fixed-priority arbiter: the lowest set request index wins.
// Produces both a one-hot grant and the matching binary index.
module fixed_priority_arbiter
    import operand_reader_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int IDX_W       = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] grant_oh,
    output logic [IDX_W-1:0]       grant_idx
);

    // Walk from lowest to highest priority so index 0 overrides everything.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
                grant_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/operand_reader.sv
// Multi-client immediate/displacement reader: pops 0..MAX_BYTES bytes from the
// instruction byte FIFO, assembles them little-endian and optionally sign-extends.
module operand_reader
    import operand_reader_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int MAX_BYTES   = 4,
    localparam int OW = 8 * MAX_BYTES,
    localparam int CW = $clog2(MAX_BYTES + 1),
    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CLIENTS-1:0]       start,
    input  logic [NUM_CLIENTS-1:0][CW-1:0] num_bytes,
    input  logic [NUM_CLIENTS-1:0]       sign_extend,
    input  logic                         flush,
    output logic [NUM_CLIENTS-1:0]       complete,
    output logic [OW-1:0]                operand,
    output logic                         busy,
    output logic                         fifo_rd_en,
    input  logic [7:0]                   fifo_rd_data,
    input  logic                         fifo_empty,
    output logic [1:0]                   dbg_state,
    output logic [IW-1:0]                dbg_grant
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] READ = ST_READ;
    localparam logic [1:0] DONE = ST_DONE;

    // Handshake: a client raises start and holds it; it is granted only in IDLE
    // without flush, and drops start the cycle after its one-cycle complete pulse.

    logic [1:0]             state_q;
    logic [IW-1:0]          grant_idx_q;
    logic [NUM_CLIENTS-1:0] grant_oh_q;
    logic [CW-1:0]          nb_q;
    logic                   sext_q;
    logic [CW-1:0]          count_q;
    logic [OW-1:0]          asm_q;
    logic [OW-1:0]          operand_q;

    logic [NUM_CLIENTS-1:0] arb_oh;
    logic [IW-1:0]          arb_idx;
    logic [CW-1:0]          nb_sel;
    logic [CW-1:0]          nb_clamped;
    logic [7:0]             last_byte;
    logic [7:0]             fill;
    logic [OW-1:0]          ext_value;
    logic                   done_ok;

    fixed_priority_arbiter #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IW)
    ) u_arb (
        .req       (start),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx)
    );

    assign nb_sel     = num_bytes[arb_idx];
    assign nb_clamped = (nb_sel > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : nb_sel;

    // Lanes below nb_q carry FIFO bytes; the rest take the fill of the last byte.
    // A zero-length request finds no last byte, so the fill stays 0.
    always_comb begin
        last_byte = 8'h00;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (nb_q == CW'(i + 1)) begin
                last_byte = asm_q[8*i +: 8];
            end
        end
        fill      = sign_fill(last_byte, sext_q);
        ext_value = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            ext_value[8*i +: 8] = (CW'(i) < nb_q) ? asm_q[8*i +: 8] : fill;
        end
    end

    assign done_ok    = (state_q == DONE) && !flush;
    assign fifo_rd_en = (state_q == READ) && !fifo_empty && !flush;
    assign complete   = done_ok ? grant_oh_q : '0;
    assign operand    = done_ok ? ext_value : operand_q;
    assign busy       = (state_q != IDLE);
    assign dbg_state  = state_q;
    assign dbg_grant  = grant_idx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            grant_oh_q  <= '0;
            nb_q        <= '0;
            sext_q      <= 1'b0;
            count_q     <= '0;
            asm_q       <= '0;
            operand_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((|start) && !flush) begin
                        grant_idx_q <= arb_idx;
                        grant_oh_q  <= arb_oh;
                        nb_q        <= nb_clamped;
                        sext_q      <= sign_extend[arb_idx];
                        count_q     <= '0;
                        asm_q       <= '0;
                        state_q     <= (nb_clamped == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (fifo_rd_en) begin
                        for (int i = 0; i < MAX_BYTES; i++) begin
                            if (count_q == CW'(i)) begin
                                asm_q[8*i +: 8] <= fifo_rd_data;
                            end
                        end
                        count_q <= count_q + CW'(1);
                        if (count_q + CW'(1) == nb_q) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A flush here discards the result and keeps the old operand.
                    if (!flush) begin
                        operand_q <= ext_value;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_reader.sv
// Directed bench for operand_reader: table of single requests plus hand-written
// sequences for arbitration, FIFO stalls, flush and mid-read reset.
module tb_operand_reader;
    import operand_reader_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        start = '0;
    logic [1:0][2:0]   num_bytes = '0;
    logic [1:0]        sign_extend = '0;
    logic              flush = 1'b0;
    logic [1:0]        complete;
    logic [31:0]       operand;
    logic              busy;
    logic              fifo_rd_en;
    logic [7:0]        fifo_rd_data = 8'h00;
    logic              fifo_empty = 1'b1;
    logic [1:0]        dbg_state;
    logic              dbg_grant;

    logic [7:0]  fifo_q[$];
    logic [31:0] exp_q[$];
    bit          hold_empty = 1'b0;
    logic [31:0] last_op = '0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          cl;
        int          nb;
        bit          sx;
        int          nbytes;
        logic [39:0] bytes;
        int          stall_at;
        int          stall_len;
        int          exp_cyc;
        logic [31:0] exp_op;
        int          exp_pops;
    } vec_t;

    vec_t vecs[10];

    operand_reader #(.NUM_CLIENTS(2), .MAX_BYTES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_bytes    (num_bytes),
        .sign_extend  (sign_extend),
        .flush        (flush),
        .complete     (complete),
        .operand      (operand),
        .busy         (busy),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .dbg_state    (dbg_state),
        .dbg_grant    (dbg_grant)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic update_fifo();
        fifo_empty   = hold_empty || (fifo_q.size() == 0);
        fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic load_fifo(input int n, input logic [39:0] b);
        logic [39:0] bb;
        bb = b;
        fifo_q.delete();
        for (int k = 0; k < n; k++) fifo_q.push_back(bb[8*k +: 8]);
        update_fifo();
    endtask

    // advance to next cycle; pop the bench FIFO if the DUT strobed it
    task automatic next_cycle(input bit rd);
        @(posedge clk);
        #1;
        if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
        update_fifo();
    endtask

    task automatic run_req(input vec_t v, input string nm);
        int cyc;
        int pops;
        int stall_cnt;
        bit seen;
        bit rd;
        logic [1:0] want_c;
        want_c = 2'b01 << v.cl;
        load_fifo(v.nbytes, v.bytes);
        num_bytes[v.cl]   = 3'(v.nb);
        sign_extend[v.cl] = v.sx;
        hold_empty = 1'b0;
        update_fifo();
        start[v.cl] = 1'b1;
        pops = 0; stall_cnt = 0; seen = 1'b0; cyc = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            rd = fifo_rd_en;
            if (cyc == 0) check({nm, "_busy_c0"}, 32'(busy), 32'd0);
            check({nm, "_rd_when_empty"}, 32'(fifo_rd_en & fifo_empty), 32'd0);
            if (complete != 2'b00) begin
                seen = 1'b1;
                check({nm, "_cycle"}, 32'(cyc), 32'(v.exp_cyc));
                check({nm, "_complete"}, 32'(complete), 32'(want_c));
                check({nm, "_operand"}, operand, v.exp_op);
                check({nm, "_busy_done"}, 32'(busy), 32'd1);
                check({nm, "_state_done"}, 32'(dbg_state), 32'(ST_DONE));
            end
            if (rd) pops++;
            if (rd && v.stall_at != 0 && pops == v.stall_at) stall_cnt = v.stall_len;
            else if (stall_cnt > 0) stall_cnt--;
            hold_empty = (stall_cnt > 0);
            next_cycle(rd);
            cyc++;
        end
        if (!seen) check({nm, "_timeout"}, 32'd1, 32'd0);
        check({nm, "_pops"}, 32'(pops), 32'(v.exp_pops));
        start[v.cl] = 1'b0;
        hold_empty = 1'b0;
        update_fifo();
        last_op = v.exp_op;
    endtask

    initial begin
        bit rd;
        int n_done;
        int pops;
        logic [1:0] done_bits;
        logic [31:0] exp_op;

        // cl nb sx nbytes bytes stall_at stall_len cyc operand pops
        vecs[0] = '{0, 2, 1'b0, 2, 40'h0000001234, 0, 0, 3, 32'h00001234, 2};
        vecs[1] = '{1, 1, 1'b1, 1, 40'h0000000080, 0, 0, 2, 32'hFFFFFF80, 1};
        vecs[2] = '{1, 1, 1'b1, 1, 40'h000000007F, 0, 0, 2, 32'h0000007F, 1};
        vecs[3] = '{0, 2, 1'b0, 2, 40'h0000000201, 1, 3, 6, 32'h00000201, 2};
        vecs[4] = '{0, 0, 1'b1, 0, 40'h0000000000, 0, 0, 1, 32'h00000000, 0};
        vecs[5] = '{1, 7, 1'b0, 5, 40'h5544332211, 0, 0, 5, 32'h44332211, 4};
        vecs[6] = '{0, 3, 1'b1, 3, 40'h0000800000, 0, 0, 4, 32'hFF800000, 3};
        vecs[7] = '{1, 3, 1'b0, 3, 40'h0000800000, 0, 0, 4, 32'h00800000, 3};
        vecs[8] = '{0, 4, 1'b1, 4, 40'h00DEADBEEF, 0, 0, 5, 32'hDEADBEEF, 4};
        vecs[9] = '{1, 2, 1'b1, 2, 40'h0000007FFF, 0, 0, 3, 32'h00007FFF, 2};

        // reset state
        update_fifo();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_operand", operand, 32'd0);
        check("rst_complete", 32'(complete), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        reset = 1'b1;
        next_cycle(1'b0);

        for (int i = 0; i < 10; i++) run_req(vecs[i], $sformatf("vec%0d", i));

        // both clients at once: client 0 first, client 1 after one IDLE cycle
        load_fifo(5, 40'hAA12345678);
        num_bytes[0] = 3'd4; num_bytes[1] = 3'd1; sign_extend = 2'b00;
        exp_q.push_back(32'h12345678);
        exp_q.push_back(32'h000000AA);
        start = 2'b11;
        n_done = 0; pops = 0;
        for (int cyc = 0; cyc < 40 && n_done < 2; cyc++) begin
            @(negedge clk);
            rd = fifo_rd_en;
            if (rd) pops++;
            check("both_onehot", 32'($countones(complete) <= 1), 32'd1);
            done_bits = complete;
            if (complete != 2'b00) begin
                exp_op = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
                check("both_complete", 32'(complete), (n_done == 0) ? 32'd1 : 32'd2);
                check("both_cycle", 32'(cyc), (n_done == 0) ? 32'd5 : 32'd8);
                check("both_operand", operand, exp_op);
                n_done++;
            end
            next_cycle(rd);
            start = start & ~done_bits;
        end
        check("both_count", 32'(n_done), 32'd2);
        check("both_pops", 32'(pops), 32'd5);
        start = 2'b00;
        last_op = 32'h000000AA;

        // flush in READ after one byte
        load_fifo(4, 40'h0004030201);
        num_bytes[0] = 3'd4; sign_extend[0] = 1'b0;
        start[0] = 1'b1;
        @(negedge clk);
        next_cycle(1'b0);
        @(negedge clk);
        check("flush_pop1", 32'(fifo_rd_en), 32'd1);
        next_cycle(fifo_rd_en);
        flush = 1'b1;
        @(negedge clk);
        check("flush_rd_en", 32'(fifo_rd_en), 32'd0);
        check("flush_complete", 32'(complete), 32'd0);
        check("flush_operand", operand, last_op);
        next_cycle(1'b0);
        flush = 1'b0; start[0] = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", 32'(busy), 32'd0);
        check("flush_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("flush_idle_operand", operand, last_op);
        // flush in IDLE blocks the grant
        next_cycle(1'b0);
        flush = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        next_cycle(1'b0);
        @(negedge clk);
        check("flush_idle_nogrant", 32'(busy), 32'd0);
        next_cycle(1'b0);
        flush = 1'b0; start[0] = 1'b0;
        // flush in DONE of a zero-length request
        num_bytes[1] = 3'd0; start[1] = 1'b1;
        @(negedge clk);
        next_cycle(1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_done_busy", 32'(busy), 32'd1);
        check("flush_done_complete", 32'(complete), 32'd0);
        check("flush_done_operand", operand, last_op);
        next_cycle(1'b0);
        flush = 1'b0; start[1] = 1'b0;
        @(negedge clk);
        check("flush_done_idle", 32'(busy), 32'd0);
        check("flush_done_kept", operand, last_op);
        next_cycle(1'b0);

        // reset mid-READ after one byte
        load_fifo(4, 40'h0044332211);
        num_bytes[0] = 3'd4; sign_extend[0] = 1'b1;
        start[0] = 1'b1;
        @(negedge clk);
        next_cycle(1'b0);
        @(negedge clk);
        check("rstmid_pop1", 32'(fifo_rd_en), 32'd1);
        next_cycle(fifo_rd_en);
        reset = 1'b0; start[0] = 1'b0;
        @(negedge clk);
        check("rstmid_operand", operand, 32'd0);
        check("rstmid_complete", 32'(complete), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rstmid_grant", 32'(dbg_grant), 32'd0);
        next_cycle(1'b0);
        reset = 1'b1;
        fifo_q.delete();
        update_fifo();
        next_cycle(1'b0);
        run_req('{1, 2, 1'b0, 2, 40'h000000ABCD, 0, 0, 3, 32'h0000ABCD, 2}, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
